neuron_tick_scheduler: RTL and testbench

NEURON_TICK_SCHEDULER -- requirements
Module: neuron_tick_scheduler

---
 rtl/neuron_pkg.sv | 29 ++
 rtl/neuron_tick_scheduler_lif_update.sv | 50 +++++
 rtl/neuron_tick_scheduler.sv | 175 +++++++++++++++++
 tb/tb_neuron_tick_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neuron_pkg
// Description : Shared types and constants for the time-multiplexed
//               leaky-integrate-and-fire tick scheduler: FSM state encoding,
//               configuration select codes and reset values.
// Revision    : 1.0 - initial release
// ============================================================================
package neuron_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // cfg_sel codes
    localparam logic [1:0] c_cfg_threshold  = 2'd0;
    localparam logic [1:0] c_cfg_leak_shift = 2'd1;
    localparam logic [1:0] c_cfg_weight     = 2'd2;
    localparam logic [1:0] c_cfg_clear_err  = 2'd3;

    // Reset values of the configuration registers
    localparam int         c_rst_threshold  = 128;
    localparam logic [2:0] c_rst_leak_shift = 3'd2;

endpackage : neuron_pkg
`default_nettype wire

// File: rtl/neuron_tick_scheduler_lif_update.sv
`default_nettype none
// ============================================================================
// Module      : lif_update
// Description : Combinational leaky-integrate-and-fire update for a single
//               neuron. Shared by all neurons, one neuron per cycle.
//   u          in  W  current membrane value
//   weight     in  W  synaptic weight of this neuron
//   stim_bit   in  1  input spike for this neuron
//   threshold  in  W  firing threshold
//   leak_shift in  3  leak shift amount (0 disables leak)
//   u_next     out W  membrane value to store back
//   spike      out 1  neuron fired this timestep
// Revision    : 1.0 - initial release
// ============================================================================
module lif_update #(
    parameter int W = 8
) (
    input  logic [W-1:0] u,
    input  logic [W-1:0] weight,
    input  logic         stim_bit,
    input  logic [W-1:0] threshold,
    input  logic [2:0]   leak_shift,
    output logic [W-1:0] u_next,
    output logic         spike
);

    logic [W-1:0] leak;
    logic [W-1:0] contrib;
    logic [W:0]   sum;
    logic [W-1:0] sat;

    always_comb begin
        // A zero shift means "no leak", not "leak the whole membrane"
        leak    = (leak_shift == 3'd0) ? '0 : (u >> leak_shift);
        contrib = stim_bit ? weight : '0;
        // leak <= u, so the subtraction cannot underflow; the extra bit
        // catches overflow of the addition for saturation
        sum     = {1'b0, u - leak} + {1'b0, contrib};
        sat     = sum[W] ? {W{1'b1}} : sum[W-1:0];
        if (sat >= threshold) begin
            spike  = 1'b1;
            u_next = '0;
        end else begin
            spike  = 1'b0;
            u_next = sat;
        end
    end

endmodule : lif_update
`default_nettype wire

// File: rtl/neuron_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : neuron_tick_scheduler
// Description : Time-multiplexed LIF neuron array. Each accepted tick runs
//               one timestep, updating neurons 0..N_NEURONS-1 one per cycle
//               through a single shared lif_update instance.
//   clk      in  1          clock, rising edge
//   rst_n    in  1          synchronous active-low reset
//   ena      in  1          enable; low freezes all state, ignores tick/cfg
//   tick     in  1          start a timestep (accepted in IDLE)
//   stim     in  N_NEURONS  input spikes, captured on accepted tick
//   cfg_we   in  1          config write strobe
//   cfg_sel  in  2          0 threshold, 1 leak_shift, 2 weight, 3 clear err
//   cfg_addr in  3          neuron index for weight writes
//   cfg_data in  W          config write data
//   busy     out 1          timestep in progress (RUN or DONE)
//   done     out 1          one-cycle completion pulse
//   spikes   out N_NEURONS  spike vector of the last completed timestep
//   err      out 1          sticky: tick/cfg write rejected while busy
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_tick_scheduler
    import neuron_pkg::*;
#(
    parameter int N_NEURONS = 8,
    parameter int W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 tick,
    input  logic [N_NEURONS-1:0] stim,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_sel,
    input  logic [2:0]           cfg_addr,
    input  logic [W-1:0]         cfg_data,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spikes,
    output logic                 err
);

    localparam int               IDX_W      = $clog2(N_NEURONS);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_NEURONS - 1);

    state_t                 state_q,  state_d;
    logic [IDX_W-1:0]       idx_q,    idx_d;
    logic [N_NEURONS-1:0]   stim_q,   stim_d;
    logic [N_NEURONS-1:0]   shadow_q, shadow_d;
    logic [N_NEURONS-1:0]   spikes_q, spikes_d;
    logic                   err_q,    err_d;
    logic [W-1:0]           thresh_q, thresh_d;
    logic [2:0]             leak_q,   leak_d;
    logic [W-1:0]           mem_q [N_NEURONS];
    logic [W-1:0]           mem_d [N_NEURONS];
    logic [W-1:0]           wgt_q [N_NEURONS];
    logic [W-1:0]           wgt_d [N_NEURONS];

    logic                   w_busy;
    logic [IDX_W-1:0]       w_cfg_idx;
    logic [W-1:0]           w_u_next;
    logic                   w_spike;

    assign w_busy    = (state_q != ST_IDLE);
    assign w_cfg_idx = cfg_addr[IDX_W-1:0];

    assign busy   = w_busy;
    assign done   = (state_q == ST_DONE);
    assign spikes = spikes_q;
    assign err    = err_q;

    lif_update #(
        .W (W)
    ) u_lif (
        .u          (mem_q[idx_q]),
        .weight     (wgt_q[idx_q]),
        .stim_bit   (stim_q[idx_q]),
        .threshold  (thresh_q),
        .leak_shift (leak_q),
        .u_next     (w_u_next),
        .spike      (w_spike)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stim_d   = stim_q;
        shadow_d = shadow_q;
        spikes_d = spikes_q;
        err_d    = err_q;
        thresh_d = thresh_q;
        leak_d   = leak_q;
        mem_d    = mem_q;
        wgt_d    = wgt_q;

        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_d  = ST_RUN;
                        stim_d   = stim;
                        idx_d    = '0;
                        shadow_d = '0;
                    end
                end
                ST_RUN: begin
                    mem_d[idx_q]    = w_u_next;
                    shadow_d[idx_q] = w_spike;
                    if (idx_q == c_last_idx) begin
                        state_d  = ST_DONE;
                        idx_d    = '0;
                        // Publish including the last neuron's bit so the
                        // output is valid in the same cycle done pulses
                        spikes_d = shadow_d;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase

            if (tick && w_busy) begin
                err_d = 1'b1;
            end

            // Writes in IDLE land before the first RUN cycle, so a tick in
            // the same cycle already sees the new value
            if (cfg_we) begin
                if (cfg_sel == c_cfg_clear_err) begin
                    err_d = 1'b0;
                end else if (w_busy) begin
                    err_d = 1'b1;
                end else begin
                    case (cfg_sel)
                        c_cfg_threshold:  thresh_d          = cfg_data;
                        c_cfg_leak_shift: leak_d            = cfg_data[2:0];
                        c_cfg_weight:     wgt_d[w_cfg_idx]  = cfg_data;
                        default:          ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            stim_q   <= '0;
            shadow_q <= '0;
            spikes_q <= '0;
            err_q    <= 1'b0;
            thresh_q <= W'(c_rst_threshold);
            leak_q   <= c_rst_leak_shift;
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i] <= '0;
                wgt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            stim_q   <= stim_d;
            shadow_q <= shadow_d;
            spikes_q <= spikes_d;
            err_q    <= err_d;
            thresh_q <= thresh_d;
            leak_q   <= leak_d;
            mem_q    <= mem_d;
            wgt_q    <= wgt_d;
        end
    end

endmodule : neuron_tick_scheduler
`default_nettype wire

// File: tb/tb_neuron_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_tick_scheduler
// Description : Self-checking bench for neuron_tick_scheduler. A table of
//               timesteps (optional same-cycle config write, stim, expected
//               spikes) is applied in order with state carried across rows,
//               followed by hand-written busy-error, enable-freeze and
//               mid-run reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_tick_scheduler;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       tick;
    logic [7:0] stim;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       busy;
    logic       done;
    logic [7:0] spikes;
    logic       err;

    int checks   = 0;
    int failures = 0;

    neuron_tick_scheduler #(
        .N_NEURONS (8),
        .W         (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .tick     (tick),
        .stim     (stim),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .busy     (busy),
        .done     (done),
        .spikes   (spikes),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       do_cfg;
        logic [1:0] sel;
        logic [2:0] addr;
        logic [7:0] data;
        logic [7:0] stim;
        logic [7:0] exp_spikes;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance negedge by negedge until done is seen or the budget expires.
    // k counts cycles after the tick-accepting cycle.
    task automatic wait_done(inout int k);
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Launch a timestep (with optional same-cycle config write); on return
    // the bench is at the negedge of cycle t+1.
    task automatic launch(input logic do_cfg, input logic [1:0] sel,
                          input logic [2:0] addr, input logic [7:0] data,
                          input logic [7:0] s);
        @(negedge clk);
        tick     = 1'b1;
        stim     = s;
        cfg_we   = do_cfg;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk);
        tick   = 1'b0;
        cfg_we = 1'b0;
        stim   = 8'h00;
    endtask

    initial begin
        int k;
        rst_n = 1'b0; ena = 1'b1; tick = 1'b0; stim = 8'h00;
        cfg_we = 1'b0; cfg_sel = 2'd0; cfg_addr = 3'd0; cfg_data = 8'h00;

        //          cfg   sel   addr  data    stim   spikes
        vecs[0]  = '{1'b0, 2'd0, 3'd0, 8'd0,   8'hFF, 8'h00}; // no config: nothing fires
        vecs[1]  = '{1'b1, 2'd2, 3'd3, 8'd200, 8'h08, 8'h08}; // w3=200 >= 128
        vecs[2]  = '{1'b1, 2'd1, 3'd0, 8'd0,   8'h00, 8'h00}; // leak off
        vecs[3]  = '{1'b1, 2'd2, 3'd0, 8'd50,  8'h01, 8'h00}; // u0=50
        vecs[4]  = '{1'b0, 2'd0, 3'd0, 8'd0,   8'h01, 8'h00}; // u0=100
        vecs[5]  = '{1'b0, 2'd0, 3'd0, 8'd0,   8'h01, 8'h01}; // u0=150 fires
        vecs[6]  = '{1'b1, 2'd0, 3'd0, 8'd255, 8'h00, 8'h00}; // threshold 255
        vecs[7]  = '{1'b1, 2'd2, 3'd1, 8'd255, 8'h02, 8'h02}; // 255 meets 255
        vecs[8]  = '{1'b0, 2'd0, 3'd0, 8'd0,   8'h02, 8'h02};
        vecs[9]  = '{1'b0, 2'd0, 3'd0, 8'd0,   8'h0B, 8'h02}; // u0=50, u3=200
        vecs[10] = '{1'b0, 2'd0, 3'd0, 8'd0,   8'h09, 8'h08}; // u3 400 saturates
        vecs[11] = '{1'b1, 2'd0, 3'd0, 8'd0,   8'h00, 8'hFF}; // threshold 0
        vecs[12] = '{1'b1, 2'd0, 3'd0, 8'd128, 8'h00, 8'h00};
        vecs[13] = '{1'b1, 2'd1, 3'd0, 8'd1,   8'h08, 8'h08}; // leak shift 1
        vecs[14] = '{1'b1, 2'd2, 3'd2, 8'd100, 8'h04, 8'h00}; // u2=100
        vecs[15] = '{1'b0, 2'd0, 3'd0, 8'd0,   8'h04, 8'h04}; // 100-50+100=150

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_spikes", {24'd0, spikes}, 32'h00);
        check("rst_err",    {31'd0, err}, 32'd0);
        check("rst_thresh", {24'd0, dut.thresh_q}, 32'd128);
        check("rst_leak",   {29'd0, dut.leak_q}, 32'd2);

        for (int i = 0; i < 16; i++) begin
            launch(vecs[i].do_cfg, vecs[i].sel, vecs[i].addr, vecs[i].data, vecs[i].stim);
            k = 1;
            wait_done(k);
            check($sformatf("row%0d_latency", i), k, 32'd9);
            check($sformatf("row%0d_spikes", i), {24'd0, spikes}, {24'd0, vecs[i].exp_spikes});
            @(negedge clk);
            check($sformatf("row%0d_idle", i), {31'd0, busy}, 32'd0);
            if (i == 0) begin
                for (int n = 0; n < 8; n++)
                    check($sformatf("row0_mem%0d", n), {24'd0, dut.mem_q[n]}, 32'd0);
            end
            if (i == 1) check("row1_mem3", {24'd0, dut.mem_q[3]}, 32'd0);
        end

        // Tick and threshold write while busy: both rejected, err sticky
        launch(1'b0, 2'd0, 3'd0, 8'd0, 8'h00);
        k = 1;
        @(negedge clk); k++;
        @(negedge clk); k++;
        tick = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd5;
        @(negedge clk); k++;
        tick = 1'b0; cfg_we = 1'b0;
        check("busy_err_set", {31'd0, err}, 32'd1);
        wait_done(k);
        check("busy_latency", k, 32'd9);
        @(negedge clk);
        check("busy_thresh", {24'd0, dut.thresh_q}, 32'd128);
        check("busy_err_sticky", {31'd0, err}, 32'd1);
        check("busy_no_restart", {31'd0, busy}, 32'd0);
        cfg_we = 1'b1; cfg_sel = 2'd3;
        @(negedge clk);
        cfg_we = 1'b0;
        check("err_cleared", {31'd0, err}, 32'd0);

        // Enable low for 5 cycles mid-run: progress freezes, tick ignored
        launch(1'b0, 2'd0, 3'd0, 8'd0, 8'h08);
        k = 1;
        @(negedge clk); k++;
        @(negedge clk); k++;
        ena = 1'b0; tick = 1'b1;
        repeat (5) begin @(negedge clk); k++; end
        check("ena_hold_busy", {31'd0, busy}, 32'd1);
        ena = 1'b1; tick = 1'b0;
        wait_done(k);
        check("ena_latency", k, 32'd14);
        check("ena_spikes", {24'd0, spikes}, 32'h08);
        check("ena_no_err", {31'd0, err}, 32'd0);
        @(negedge clk);

        // Reset sampled at t+4 aborts the timestep
        launch(1'b0, 2'd0, 3'd0, 8'd0, 8'h08);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_run_busy",   {31'd0, busy}, 32'd0);
        check("rst_run_done",   {31'd0, done}, 32'd0);
        check("rst_run_spikes", {24'd0, spikes}, 32'h00);
        check("rst_run_mem3",   {24'd0, dut.mem_q[3]}, 32'd0);
        check("rst_run_mem0",   {24'd0, dut.mem_q[0]}, 32'd0);
        check("rst_run_wgt3",   {24'd0, dut.wgt_q[3]}, 32'd0);
        check("rst_run_thresh", {24'd0, dut.thresh_q}, 32'd128);
        k = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) k++;
        end
        check("rst_run_no_done", k, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_neuron_tick_scheduler
`default_nettype wire
